// File: rtl/saturn_bus_arbiter.sv
// ============================================================================
// saturn_bus_arbiter
//   Nibble-bus arbiter and phase sequencer for NUM_DEV Saturn peripherals.
//   Optional multi-driver detection: define SATURN_BUS_CONFLICT_DETECT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module saturn_bus_arbiter #(
  parameter int NUM_DEV = 4,
  parameter int PHASES  = 4,
  parameter int CTR_W   = 32,
  parameter int TIMEOUT = 16,
  localparam int SEL_W  = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1,
  localparam int PH_W   = (PHASES > 1) ? $clog2(PHASES) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_clk_en,
  input  logic                 i_stall,
  input  logic                 i_ctrl_bus_clk_en,
  input  logic                 i_ctrl_halt,
  input  logic [NUM_DEV-1:0]   i_dev_active,
  input  logic [4*NUM_DEV-1:0] i_dev_nibbles,
  output logic                 o_bus_clk_en,
  output logic [3:0]           o_nibble,
  output logic [SEL_W-1:0]     o_sel,
  output logic [PHASES-1:0]    o_phases,
  output logic [PH_W-1:0]      o_phase,
  output logic [CTR_W-1:0]     o_cycle_ctr,
  output logic                 o_timeout,
  output logic                 o_conflict,
  output logic [NUM_DEV-1:0]   o_conflict_mask,
  output logic                 o_halt
);

  localparam int IDLE_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic              w_bus_clk_en;
  logic              w_advance;
  logic              w_timeout;
  logic [SEL_W-1:0]  w_sel;
  logic [PH_W-1:0]   w_phase;
  logic [PHASES-1:0] r_phases;
  logic [CTR_W-1:0]  r_cycle_ctr;

  assign w_bus_clk_en = i_clk_en & i_ctrl_bus_clk_en;
  assign w_advance    = i_clk_en & ~i_stall & ~o_halt;

  // Later iterations overwrite earlier ones, so the highest active index wins.
  always_comb begin
    w_sel = '0;
    for (int k = 0; k < NUM_DEV; k++) begin
      if (i_dev_active[k]) w_sel = SEL_W'(k);
    end
  end

  always_comb begin
    w_phase = '0;
    for (int p = 0; p < PHASES; p++) begin
      if (r_phases[p]) w_phase = w_phase | PH_W'(p);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_phases    <= PHASES'(1);
      r_cycle_ctr <= '0;
    end else if (w_advance) begin
      r_phases <= {r_phases[PHASES-2:0], r_phases[PHASES-1]};
      if (r_phases[PHASES-1]) r_cycle_ctr <= r_cycle_ctr + 1'b1;
    end
  end

  generate
    if (TIMEOUT > 0) begin : g_timeout
      localparam logic [IDLE_W-1:0] c_timeout_val = IDLE_W'(TIMEOUT);
      logic [IDLE_W-1:0] r_idle;
      logic              r_timeout;

      // Idle tracking follows bus-enabled clocks only; stall does not gate it.
      always_ff @(posedge i_clk) begin
        if (i_reset) begin
          r_idle    <= '0;
          r_timeout <= 1'b0;
        end else if (w_bus_clk_en) begin
          if (|i_dev_active) begin
            r_idle <= '0;
          end else if (r_idle != c_timeout_val) begin
            r_idle <= r_idle + 1'b1;
            if (r_idle == c_timeout_val - 1'b1) r_timeout <= 1'b1;
          end
        end
      end
      assign w_timeout = r_timeout;
    end else begin : g_no_timeout
      assign w_timeout = 1'b0;
    end
  endgenerate

`ifdef SATURN_BUS_CONFLICT_DETECT_EN
  logic               r_conflict;
  logic [NUM_DEV-1:0] r_conflict_mask;
  logic               w_multi;

  // x & (x-1) is nonzero exactly when two or more bits are set.
  assign w_multi = |(i_dev_active & (i_dev_active - 1'b1));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_conflict      <= 1'b0;
      r_conflict_mask <= '0;
    end else if (w_bus_clk_en && w_multi && !r_conflict) begin
      r_conflict      <= 1'b1;
      r_conflict_mask <= i_dev_active;
    end
  end
  assign o_conflict      = r_conflict;
  assign o_conflict_mask = r_conflict_mask;
`else
  assign o_conflict      = 1'b0;
  assign o_conflict_mask = '0;
`endif

  assign o_bus_clk_en = w_bus_clk_en;
  assign o_sel        = w_sel;
  assign o_nibble     = i_dev_nibbles[{w_sel, 2'b00} +: 4];
  assign o_phases     = r_phases;
  assign o_phase      = w_phase;
  assign o_cycle_ctr  = r_cycle_ctr;
  assign o_timeout    = w_timeout;
  assign o_halt       = i_ctrl_halt | w_timeout | o_conflict;

endmodule

`default_nettype wire

// File: tb/tb_saturn_bus_arbiter.sv
// ============================================================================
// tb_saturn_bus_arbiter
//   Directed self-checking bench for saturn_bus_arbiter (CTR_W = 4).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_saturn_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en, stall, ctrl_bus_clk_en, ctrl_halt;
  logic [3:0]  dev_active;
  logic [15:0] dev_nibbles;
  logic        bus_clk_en, timeout, conflict, halt;
  logic [3:0]  nibble, phases, cycle_ctr, conflict_mask;
  logic [1:0]  sel, phase;

  int n_checks = 0;
  int n_errors = 0;

  saturn_bus_arbiter #(.NUM_DEV(4), .PHASES(4), .CTR_W(4), .TIMEOUT(16)) dut (
    .i_clk            (clk),
    .i_reset          (rst),
    .i_clk_en         (clk_en),
    .i_stall          (stall),
    .i_ctrl_bus_clk_en(ctrl_bus_clk_en),
    .i_ctrl_halt      (ctrl_halt),
    .i_dev_active     (dev_active),
    .i_dev_nibbles    (dev_nibbles),
    .o_bus_clk_en     (bus_clk_en),
    .o_nibble         (nibble),
    .o_sel            (sel),
    .o_phases         (phases),
    .o_phase          (phase),
    .o_cycle_ctr      (cycle_ctr),
    .o_timeout        (timeout),
    .o_conflict       (conflict),
    .o_conflict_mask  (conflict_mask),
    .o_halt           (halt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_ph;
    rst = 1'b1; clk_en = 1'b0; stall = 1'b0; ctrl_bus_clk_en = 1'b0;
    ctrl_halt = 1'b0; dev_active = '0; dev_nibbles = 16'h7A53;
    do_reset();

    chk("rst_phases", phases, 1);
    chk("rst_phase", phase, 0);
    chk("rst_ctr", cycle_ctr, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_conflict", conflict, 0);
    chk("rst_mask", conflict_mask, 0);
    chk("rst_halt", halt, 0);

    // Phase ring walk
    clk_en = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick(1);
      exp_ph = 4'b0001 << (i % 4);
      chk("ring_phases", phases, exp_ph);
      chk("ring_phase", phase, i % 4);
      if (i == 8) chk("ring_ctr8", cycle_ctr, 2);
    end
    chk("ring_ctr9", cycle_ctr, 2);

    stall = 1'b1;
    tick(3);
    chk("stall_phases", phases, 2);
    chk("stall_ctr", cycle_ctr, 2);
    stall = 1'b0;

    clk_en = 1'b0;
    tick(1);
    chk("clken_phases", phases, 2);
    clk_en = 1'b1;

    ctrl_halt = 1'b1;
    tick(1);
    chk("ctrlhalt_phases", phases, 2);
    chk("ctrlhalt_halt", halt, 1);
    ctrl_halt = 1'b0;

    // Selection (combinational)
    dev_active = 4'b0101; #1;
    chk("sel_0101", sel, 2);
    chk("nib_0101", nibble, 4'hA);
    dev_active = 4'b0000; #1;
    chk("sel_none", sel, 0);
    chk("nib_none", nibble, 4'h3);
    dev_active = 4'b1010; #1;
    chk("sel_1010", sel, 3);
    chk("nib_1010", nibble, 4'h7);
    dev_active = 4'b0010; #1;
    chk("sel_0010", sel, 1);
    chk("nib_0010", nibble, 4'h5);
    dev_active = 4'b0000;

    ctrl_bus_clk_en = 1'b1; clk_en = 1'b0; #1;
    chk("busen_gated", bus_clk_en, 0);
    clk_en = 1'b1; #1;
    chk("busen_on", bus_clk_en, 1);
    ctrl_bus_clk_en = 1'b0;

    // Cycle counter wrap: 17 full cycles with CTR_W = 4
    do_reset();
    tick(68);
    chk("wrap_ctr", cycle_ctr, 1);
    chk("wrap_phases", phases, 1);

    // Timeout with a restart at idle count 10
    do_reset();
    ctrl_bus_clk_en = 1'b1;
    tick(10);
    dev_active = 4'b0001;
    tick(1);
    dev_active = 4'b0000;
    tick(15);
    chk("to_15", timeout, 0);
    chk("to_15_halt", halt, 0);
    chk("to_15_phases", phases, 4);
    tick(1);
    chk("to_16", timeout, 1);
    chk("to_16_halt", halt, 1);
    chk("to_16_phases", phases, 8);
    tick(3);
    chk("to_frozen_phases", phases, 8);
    chk("to_frozen_ctr", cycle_ctr, 6);
    chk("to_sticky", timeout, 1);

    // Timeout under stall, then reset in phase 2
    ctrl_bus_clk_en = 1'b0;
    do_reset();
    tick(2);
    chk("p2_phase", phase, 2);
    stall = 1'b1; ctrl_bus_clk_en = 1'b1;
    tick(16);
    chk("stall_to", timeout, 1);
    chk("stall_to_phases", phases, 4);
    rst = 1'b1; ctrl_halt = 1'b1;
    tick(1);
    chk("mid_rst_phases", phases, 1);
    chk("mid_rst_ctr", cycle_ctr, 0);
    chk("mid_rst_timeout", timeout, 0);
    chk("mid_rst_halt1", halt, 1);
    rst = 1'b0; ctrl_halt = 1'b0; stall = 1'b0; ctrl_bus_clk_en = 1'b0; #1;
    chk("mid_rst_halt0", halt, 0);

    // Conflict detection
    do_reset();
    dev_active = 4'b0011;
    tick(1);
    chk("cf_nobus", conflict, 0);
    ctrl_bus_clk_en = 1'b1;
    tick(1);
`ifdef SATURN_BUS_CONFLICT_DETECT_EN
    chk("cf_set", conflict, 1);
    chk("cf_mask", conflict_mask, 4'b0011);
    chk("cf_halt", halt, 1);
`else
    chk("cf_off", conflict, 0);
    chk("cf_off_mask", conflict_mask, 0);
    chk("cf_off_halt", halt, 0);
`endif
    dev_active = 4'b1100;
    tick(1);
`ifdef SATURN_BUS_CONFLICT_DETECT_EN
    chk("cf_mask_held", conflict_mask, 4'b0011);
    chk("cf_sticky", conflict, 1);
`else
    chk("cf_off2", conflict, 0);
    chk("cf_off_mask2", conflict_mask, 0);
`endif
    dev_active = 4'b0000; ctrl_bus_clk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
